// File: rtl/thumb_fetch.sv
// thumb_fetch -- instruction fetch unit for a 16-bit Thumb-style pipeline.
//
// Issues single-cycle active-low read strobes to an instruction memory,
// captures the returned halfword at the edge that ends the strobe cycle,
// and buffers it with its address in a small prefetch queue feeding decode.
// A fetched SWI (opcode [15:8] == 8'hDF) is queued and then halts fetching
// until the execute stage redirects with branch_taken.
//
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : prefetch queue entries (2..4)
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-high reset
//   read_instruction_n  out  registered active-low memory read strobe
//   instruction_address out  registered halfword fetch address
//   instruction         in   memory read data, sampled at end of strobe cycle
//   branch_taken        in   redirect request (flushes queue)
//   branch_target       in   redirect address (bit 0 ignored)
//   stall               in   decode cannot accept the queue head this cycle
//   if_valid            out  queue head is valid
//   if_instr            out  queue head instruction
//   if_pc               out  queue head address
module thumb_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        read_instruction_n,
  output logic [31:0] instruction_address,
  input  logic [15:0] instruction,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
  localparam logic [3:0] DEPTH_W  = 4'(DEPTH);
  localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  count_r;
  logic [2:0]  count_next_s;
  logic [3:0]  count_sum_s;
  logic [1:0]  rd_ptr_r;
  logic [1:0]  wr_ptr_r;
  logic [15:0] q_instr_r [DEPTH];
  logic [31:0] q_pc_r    [DEPTH];
  logic        read_n_r;
  logic [31:0] addr_r;
  logic        branch_s;
  logic        push_s;
  logic        pop_s;
  logic        swi_s;
  logic        fetch_next_s;
  logic [31:0] addr_next_s;

  // Wrap a queue pointer at DEPTH entries.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    logic [1:0] r;
    if (p == LAST_IDX) begin
      r = 2'd0;
    end else begin
      r = p + 2'd1;
    end
    return r;
  endfunction

  // A redirect is ignored in IDLE; elsewhere it overrides push, pop and SWI.
  // A push happens on the edge ending a strobe cycle (strobe is registered).
  assign branch_s = branch_taken && (state_r != IDLE);
  assign push_s   = !read_n_r && !branch_s;
  assign pop_s    = (count_r != 3'd0) && !stall && !branch_s;
  assign swi_s    = push_s && (instruction[15:8] == 8'hDF);

  // Next occupancy: count + push - pop, clamped to DEPTH, zero on flush.
  always_comb begin
    count_sum_s = {1'b0, count_r} + {3'd0, push_s};
    if (pop_s) begin
      count_sum_s = count_sum_s - 4'd1;
    end else begin
      count_sum_s = count_sum_s;
    end
    if (branch_s) begin
      count_next_s = 3'd0;
    end else if (count_sum_s > DEPTH_W) begin
      count_next_s = DEPTH_C;
    end else begin
      count_next_s = count_sum_s[2:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: state_next_s = RUN;
      RUN: begin
        if (branch_s) begin
          state_next_s = RUN;
        end else if (swi_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT: begin
        if (branch_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output logic: decide whether and where to fetch next cycle.
  // addr_r always holds the most recently issued fetch address, so the
  // sequential address after a stall gap is still that address + 2.
  always_comb begin
    fetch_next_s = (state_next_s == RUN) && (count_next_s < DEPTH_C);
    addr_next_s  = addr_r;
    if (!fetch_next_s) begin
      addr_next_s = addr_r;
    end else if (state_r == IDLE) begin
      addr_next_s = RESET_PC;
    end else if (branch_s) begin
      addr_next_s = branch_target & 32'hFFFF_FFFE;
    end else begin
      addr_next_s = addr_r + 32'd2;
    end
  end

  // Registered memory strobe and address; reset drops the strobe at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_n_r <= 1'b1;
      addr_r   <= RESET_PC;
    end else begin
      read_n_r <= !fetch_next_s;
      addr_r   <= addr_next_s;
    end
  end

  // Queue occupancy and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r  <= 3'd0;
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
    end else if (branch_s) begin
      count_r  <= 3'd0;
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
    end else begin
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Queue storage: capture the fetched halfword with its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_r[i] <= 16'h0000;
        q_pc_r[i]    <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_s && (wr_ptr_r == 2'(i))) begin
          q_instr_r[i] <= instruction;
          q_pc_r[i]    <= addr_r;
        end else begin
          q_instr_r[i] <= q_instr_r[i];
          q_pc_r[i]    <= q_pc_r[i];
        end
      end
    end
  end

  // Queue head read mux.
  always_comb begin
    if_instr = 16'h0000;
    if_pc    = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_r == 2'(i)) begin
        if_instr = q_instr_r[i];
        if_pc    = q_pc_r[i];
      end else begin
        if_instr = if_instr;
        if_pc    = if_pc;
      end
    end
  end

  assign if_valid            = (count_r != 3'd0);
  assign read_instruction_n  = read_n_r;
  assign instruction_address = addr_r;

endmodule

// File: tb/tb_thumb_fetch.sv
// Testbench for thumb_fetch: directed scenarios with literal expectations,
// then randomized stall/branch/reset traffic checked every cycle against a
// queue-based behavioural model of the fetch unit.
module tb_thumb_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_instruction_n;
  logic [31:0] instruction_address;
  logic [15:0] instruction;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [31:0] if_pc;

  logic        read_n2;
  logic [31:0] addr2;
  logic        ifv2;
  logic [15:0] ifi2;
  logic [31:0] ifp2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  thumb_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .read_instruction_n(read_instruction_n), .instruction_address(instruction_address),
    .instruction(instruction), .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  // Second instance: wrap-around reset address, deeper queue, always stalled.
  thumb_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset),
    .read_instruction_n(read_n2), .instruction_address(addr2),
    .instruction(16'h1111), .branch_taken(1'b0), .branch_target(32'h0),
    .stall(1'b1), .if_valid(ifv2), .if_instr(ifi2), .if_pc(ifp2)
  );

  // Instruction memory: explicit overrides, else a hash that never yields SWI.
  logic [15:0] mem_ov [logic [31:0]];

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [15:0] h;
    if (mem_ov.exists(a)) return mem_ov[a];
    h = (a[16:1] * 16'h9E37) ^ 16'h1234;
    if (h[15:8] == 8'hDF) h[15:8] = 8'h20;
    return h;
  endfunction

  // Behavioural model: 0 = idle, 1 = run, 2 = halt.
  int          m_state;
  logic [47:0] m_q [$];
  bit          m_fetch;
  logic [31:0] m_addr;
  bit          m_in_reset;

  logic [31:0] s2 [$];
  bit          rec2 = 1'b0;

  task automatic m_reset();
    m_state = 0;
    m_q.delete();
    m_fetch = 1'b0;
    m_addr  = RPC;
  endtask

  task automatic m_step(input bit br, input logic [31:0] tgt, input bit st);
    logic [15:0] word;
    bit          pushed;
    if (m_state == 0) begin
      m_state = 1;
      m_fetch = 1'b1;
      m_addr  = RPC;
      return;
    end
    if (br) begin
      m_q.delete();
      m_state = 1;
      m_fetch = 1'b1;
      m_addr  = {tgt[31:1], 1'b0};
      return;
    end
    pushed = m_fetch;
    word   = mem_word(m_addr);
    if (m_q.size() > 0 && !st) void'(m_q.pop_front());
    if (pushed) begin
      m_q.push_back({m_addr, word});
      if (word[15:8] == 8'hDF) m_state = 2;
    end
    if (m_state == 1 && m_q.size() < DEPTH) begin
      m_fetch = 1'b1;
      m_addr  = m_addr + 32'd2;
    end else begin
      m_fetch = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The per-cycle comparison of DUT outputs against the model.
  task automatic compare_all();
    logic [47:0] f;
    chk("read_n", {31'd0, read_instruction_n}, {31'd0, !m_fetch});
    chk("addr", instruction_address, m_addr);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_q.size() != 0});
    if (m_in_reset) begin
      chk("rst_if_instr", {16'd0, if_instr}, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
    end else if (m_q.size() != 0) begin
      f = m_q[0];
      chk("if_instr", {16'd0, if_instr}, {16'd0, f[15:0]});
      chk("if_pc", if_pc, f[47:16]);
    end
    if (rec2 && !read_n2) s2.push_back(addr2);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input bit br, input logic [31:0] tgt, input bit st, input bit rst);
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    instruction   = read_instruction_n ? 16'($urandom) : mem_word(instruction_address);
    if (rst) begin
      reset = 1'b1;
      m_reset();
      m_in_reset = 1'b1;
    end else begin
      reset = 1'b0;
      m_in_reset = 1'b0;
      m_step(br, tgt, st);
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin : main
    int n;
    int r;
    bit rb;
    bit bb;
    logic [31:0] t;
    reset = 1'b1;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    stall = 1'b0;
    instruction = 16'h0;
    m_reset();
    m_in_reset = 1'b1;
    mem_ov[32'h0]  = 16'h2100;
    mem_ov[32'h2]  = 16'h2200;
    mem_ov[32'h4]  = 16'h20FC;
    mem_ov[32'h14] = 16'h6042;
    mem_ov[32'h16] = 16'hDF00;

    @(negedge clk);
    compare_all();
    chk("rst_read_n", {31'd0, read_instruction_n}, 32'd1);
    chk("rst_addr", instruction_address, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_addr2", addr2, 32'hFFFF_FFFC);
    rec2 = 1'b1;

    // Straight-line fetch after reset release.
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("seq_strobe0", {31'd0, read_instruction_n}, 32'd0);
    chk("seq_addr0", instruction_address, 32'h0);
    chk("seq_valid0", {31'd0, if_valid}, 32'd0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("seq_addr2", instruction_address, 32'h2);
    chk("seq_valid1", {31'd0, if_valid}, 32'd1);
    chk("seq_instr", {16'd0, if_instr}, 32'h2100);
    chk("seq_pc", if_pc, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("seq_addr4", instruction_address, 32'h4);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    rec2 = 1'b0;
    chk("wrap_count", s2.size(), 32'd4);
    if (s2.size() == 4) begin
      chk("wrap_a0", s2[0], 32'hFFFF_FFFC);
      chk("wrap_a1", s2[1], 32'hFFFF_FFFE);
      chk("wrap_a2", s2[2], 32'h0000_0000);
      chk("wrap_a3", s2[3], 32'h0000_0002);
    end

    // Stalled from reset: exactly DEPTH strobes, then ordered drain.
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    n = 0;
    repeat (6) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      if (!read_instruction_n) n++;
    end
    chk("stall_strobes", n, DEPTH);
    chk("stall_idle", {31'd0, read_instruction_n}, 32'd1);
    chk("stall_head", {16'd0, if_instr}, 32'h2100);
    chk("stall_head_pc", if_pc, 32'h0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_instr", {16'd0, if_instr}, 32'h2200);
    chk("drain_pc", if_pc, 32'h2);
    chk("resume_strobe", {31'd0, read_instruction_n}, 32'd0);
    chk("resume_addr", instruction_address, 32'h4);

    // Branch with two entries queued.
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tick(1'b1, 32'h15, 1'b1, 1'b0);
    chk("br_flush", {31'd0, if_valid}, 32'd0);
    chk("br_strobe", {31'd0, read_instruction_n}, 32'd0);
    chk("br_addr", instruction_address, 32'h14);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("br_instr", {16'd0, if_instr}, 32'h6042);
    chk("br_pc", if_pc, 32'h14);

    // SWI halts fetching but is still delivered; branch resumes.
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    chk("swi_nostrobe", {31'd0, read_instruction_n}, 32'd1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("swi_instr", {16'd0, if_instr}, 32'hDF00);
    chk("swi_pc", if_pc, 32'h16);
    n = 0;
    repeat (4) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      if (!read_instruction_n) n++;
    end
    chk("halt_strobes", n, 32'd0);
    tick(1'b1, 32'h0, 1'b0, 1'b0);
    chk("halt_br_strobe", {31'd0, read_instruction_n}, 32'd0);
    chk("halt_br_addr", instruction_address, 32'h0);

    // Reset mid-fetch with one entry queued.
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
    chk("pre_rst_strobe", {31'd0, read_instruction_n}, 32'd0);
    #2;
    reset = 1'b1;
    m_reset();
    m_in_reset = 1'b1;
    #1;
    chk("async_read_n", {31'd0, read_instruction_n}, 32'd1);
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    compare_all();
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst_strobe", {31'd0, read_instruction_n}, 32'd0);
    chk("post_rst_addr", instruction_address, RPC);

    // Randomized traffic.
    mem_ov[32'h40]  = 16'hDF12;
    mem_ov[32'h1A0] = 16'hDFAA;
    mem_ov[32'h22]  = 16'hDF01;
    repeat (3000) begin
      r  = $urandom_range(0, 99);
      rb = (r < 1);
      bb = (r >= 1 && r < 7);
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 32'h3FF));
      endcase
      tick(bb, t, ($urandom_range(0, 2) == 0), rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thumb_fetch.md
THUMB_FETCH -- requirements
Module: thumb_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2: prefetch queue entries; legal values 2..4.
REQ-003 The block SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port read_instruction_n, output, 1: active-low instruction-memory read strobe.
REQ-006 The block SHALL have port instruction_address, output, 32: instruction-memory halfword address.
REQ-007 The block SHALL have port instruction, input, 16: instruction-memory read data, valid at the rising edge that ends a strobe cycle.
REQ-008 The block SHALL have port branch_taken, input, 1: redirect request from the execute stage.
REQ-009 The block SHALL have port branch_target, input, 32: redirect address.
REQ-010 The block SHALL have port stall, input, 1: decode stage cannot accept this cycle.
REQ-011 The block SHALL have port if_valid, output, 1: queue head holds a valid instruction.
REQ-012 The block SHALL have port if_instr, output, 16: queue head instruction.
REQ-013 The block SHALL have port if_pc, output, 32: address of if_instr.

Function
REQ-014 read_instruction_n and instruction_address SHALL be registered, with no combinational path from any input.
REQ-015 Fetch protocol: read_instruction_n low for one clock per fetch; instruction sampled on the edge ending that cycle and pushed with its address.
REQ-016 FSM states SHALL be IDLE, RUN and HALT.
REQ-017 IDLE is entered on reset and SHALL go to RUN on the first edge after reset release, issuing the fetch at RESET_PC for the following cycle.
REQ-018 RUN SHALL go to HALT when a pushed instruction has [15:8] == 8'hDF (SWI); the SWI itself SHALL be queued.
REQ-019 HALT SHALL go to RUN only on branch_taken.
REQ-020 Pop SHALL occur when if_valid && !stall; head advances at that edge.
REQ-021 Occupancy SHALL be count_next = count + push - pop, clamped to 0..DEPTH.
REQ-022 A fetch SHALL be issued for the next cycle iff state_next == RUN and count_next < DEPTH; otherwise read_instruction_n SHALL be 1.
REQ-023 The sequential fetch address SHALL be the previous fetch address + 2, modulo 2^32 (32'hFFFFFFFE wraps to 0).
REQ-024 On branch_taken in any state except IDLE, at that edge the block SHALL:
- flush the queue (count = 0);
- discard the instruction sampled at that edge;
- issue the next fetch at {branch_target[31:1],1'b0};
- enter RUN.
REQ-025 branch_taken SHALL override push, pop, stall and SWI detection in the same cycle.
REQ-026 if_valid SHALL equal (count != 0); if_instr/if_pc are don't-care when if_valid = 0.
REQ-027 Simultaneous push and pop when full SHALL be impossible, since fetch is issued only when count_next < DEPTH.
REQ-028 Simultaneous push and pop otherwise SHALL leave count unchanged.

Reset
REQ-029 While reset = 1, outputs SHALL be:
- read_instruction_n = 1;
- instruction_address = RESET_PC;
- if_valid = 0, if_instr = 16'h0000, if_pc = 32'h0.
REQ-030 While reset = 1, internal state SHALL be state = IDLE, count = 0, queue pointers = 0.
REQ-031 Reset asserted mid-fetch SHALL abort the fetch immediately (read_instruction_n = 1 asynchronously) and discard all queued data.

Verification
REQ-032 Reset release, stall = 0, memory program at 0x0/0x2/0x4 = 2100/2200/20FC -> strobes at 0x0, 0x2, 0x4 on consecutive cycles; if_valid rises one cycle after the first strobe with if_instr = 16'h2100, if_pc = 0.
REQ-033 stall held at 1 from reset -> exactly DEPTH strobes (0x0, 0x2); read_instruction_n then stays 1; on stall release the queue drains in order 2100@0x0 then 2200@0x2, and fetch resumes at 0x4.
REQ-034 branch_taken = 1 with branch_target = 0x15 while 2 entries are queued -> next cycle if_valid = 0 and strobe address = 0x14; the next popped instruction is 16'h6042 with if_pc = 0x14.
REQ-035 Fetch of 16'hDF00 at 0x16 -> state HALT, no further strobes; DF00 is still delivered with if_pc = 0x16; branch_taken to 0x0 resumes fetch at 0x0.
REQ-036 RESET_PC = 32'hFFFFFFFC -> strobes at FFFFFFFC, FFFFFFFE, 00000000.
REQ-037 reset asserted while read_instruction_n = 0 with 1 entry queued -> same-timestep read_instruction_n = 1 and if_valid = 0; after release, first strobe at RESET_PC.
